bin_to_bcd_seq: RTL

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 88 ++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble), one input bit per clock.
// Result lands on bcd_out with a one-cycle done pulse; busy marks the shifting phase.
module bin_to_bcd_seq #(
    parameter int BIN_W = 8,
    parameter int NDIG  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*NDIG-1:0]     bcd_out
);

    localparam int SCR_W = 4 * NDIG;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [BIN_W-1:0]       shift_reg;
    logic [SCR_W-1:0]       scratch_reg;
    logic [CNT_W-1:0]       count_reg;

    logic [SCR_W-1:0]       scratch_adj;
    logic [SCR_W+BIN_W-1:0] shifted_next;

    // Pre-shift correction: any digit >= 5 would become >= 10 after doubling.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
            assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                          ? scratch_reg[4*gi +: 4] + 4'd3
                                          : scratch_reg[4*gi +: 4];
        end
    endgenerate

    assign shifted_next = {scratch_adj, shift_reg} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            scratch_reg <= '0;
            count_reg   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd_out     <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg   <= bin_in;
                        scratch_reg <= '0;
                        count_reg   <= CNT_W'(BIN_W);
                        busy        <= 1'b1;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_reg <= shifted_next[SCR_W+BIN_W-1:BIN_W];
                    shift_reg   <= shifted_next[BIN_W-1:0];
                    count_reg   <= count_reg - CNT_W'(1);
                    // Last bit consumed on this edge: leave SHIFT so busy drops with it.
                    if (count_reg == CNT_W'(1)) begin
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    bcd_out   <= scratch_reg;
                    done      <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
